// File: rtl/mmio_pkg.sv
// Shared address map, RV32I load/store funct3 codes and LEDREG byte lanes for the MMIO responder.
package mmio_pkg;

    localparam logic [31:0] ADDR_LEDREG = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
    localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam int LANE_LED   = 0;
    localparam int LANE_BLUE  = 1;
    localparam int LANE_GREEN = 2;
    localparam int LANE_RED   = 3;

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {a, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'h0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'h0, sh[15:0]};
            F3_W:    return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mmio_timebase.sv
// Free-running microsecond / millisecond counters derived from the core clock.
module mmio_timebase
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] micros,
    output logic [31:0] millis
);

    localparam int unsigned DIV = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;

    logic [31:0] pre;
    logic [9:0]  us_cnt;
    logic        tick;

    assign tick = (pre == 32'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre    <= '0;
            us_cnt <= '0;
            micros <= '0;
            millis <= '0;
        end else begin
            pre <= tick ? '0 : pre + 32'd1;
            if (tick) begin
                micros <= micros + 32'd1;
                if (us_cnt == 10'd999) begin
                    us_cnt <= '0;
                    millis <= millis + 32'd1;
                end else begin
                    us_cnt <= us_cnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Single-cycle MMIO responder: LEDREG (r/w), MILLIS and MICROS (r/o), RGB/LED board outputs.
// Define MMIO_PWM_EN to drive RGB outputs from an 8-bit PWM instead of the colour MSB.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        LED,
    output logic        RGB_R,
    output logic        RGB_G,
    output logic        RGB_B
);

    logic [31:0] ledreg, micros, millis;
    logic        sel_led, sel_ms, sel_us, err;
    logic [31:0] word, wdat;
    logic [3:0]  be;

    mmio_timebase #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .micros (micros),
        .millis (millis)
    );

    always_comb begin
        sel_led = req_addr[31:2] == ADDR_LEDREG[31:2];
        sel_ms  = req_addr[31:2] == ADDR_MILLIS[31:2];
        sel_us  = req_addr[31:2] == ADDR_MICROS[31:2];
        err     = misaligned(req_funct3, req_addr[1:0]);
        word    = sel_led ? ledreg : sel_ms ? millis : sel_us ? micros : 32'h0;
        be      = 4'b0000;
        wdat    = req_wdata;
        // Store data is replicated across lanes so the byte enables alone pick the target
        if (!req_funct3[2]) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be   = 4'b0001 << req_addr[1:0];
                    wdat = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdat = {2{req_wdata[15:0]}};
                end
                2'b10:   be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ledreg     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (req_valid && req_we && sel_led && !err) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ledreg[i*8 +: 8] <= wdat[i*8 +: 8];
            end
            resp_valid <= req_valid;
            resp_err   <= req_valid && err;
            resp_rdata <= (req_valid && !req_we && !err) ?
                          load_fmt(req_funct3, req_addr[1:0], word) : 32'h0;
        end
    end

    assign LED = ledreg[LANE_LED*8];

`ifdef MMIO_PWM_EN
    logic [7:0] pwm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pwm <= '0;
        else        pwm <= pwm + 8'd1;
    end

    assign RGB_R = pwm < ledreg[LANE_RED*8   +: 8];
    assign RGB_G = pwm < ledreg[LANE_GREEN*8 +: 8];
    assign RGB_B = pwm < ledreg[LANE_BLUE*8  +: 8];
`else
    assign RGB_R = ledreg[LANE_RED*8   + 7];
    assign RGB_G = ledreg[LANE_GREEN*8 + 7];
    assign RGB_B = ledreg[LANE_BLUE*8  + 7];
`endif

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, core clock frequency used to derive the 1 us tick.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  in  1  core memory request strobe for this cycle.
REQ-005 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have port req_funct3  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-009 SHALL have port resp_valid  out  1  one-cycle pulse marking a completed request.
REQ-010 SHALL have port resp_rdata  out  32  load data, extended per funct3.
REQ-011 SHALL have port resp_err  out  1  misaligned access flag, qualified by resp_valid.
REQ-012 SHALL have ports LED, RGB_R, RGB_G, RGB_B  out  1 each  active-high board outputs.

Function
REQ-013 SHALL decode three 32-bit words: 0xFFFFFFFC LEDREG (read/write), 0xFFFFFFF8 MILLIS (read-only), 0xFFFFFFF4 MICROS (read-only).
REQ-014 SHALL assign LEDREG bytes: [7:0] LED, [15:8] blue, [23:16] green, [31:24] red.
REQ-015 SHALL accept a request every cycle (no back-pressure); resp_valid SHALL assert exactly 1 cycle after req_valid, back-to-back supported.
REQ-016 SHALL format loads from the addressed word using req_addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-017 SHALL apply stores to LEDREG with byte enables from req_addr[1:0] and size (SB one byte, SH two, SW four); writes to MILLIS, MICROS or unmapped addresses SHALL be ignored.
REQ-018 SHALL return 0 for loads from unmapped addresses, with resp_err = 0.
REQ-019 SHALL flag resp_err = 1 for halfword at addr[0] = 1 or word at addr[1:0] != 0; such a store SHALL NOT modify state and such a load SHALL return 0.
REQ-020 SHALL increment MICROS every CLK_FREQ_HZ/1000000 cycles via a prescaler, and MILLIS on every 1000th MICROS increment; both wrap 0xFFFFFFFF -> 0.
REQ-021 SHALL return the pre-increment counter value when a load samples a counter in the same cycle it increments.
REQ-022 SHALL make a load issued the cycle after a store to the same byte return the new data (write-then-read ordering).
REQ-023 SHALL drive LED = LEDREG[0].

Reset
REQ-024 SHALL, while reset is low, hold LEDREG, MICROS, MILLIS, prescaler and PWM counter at 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, and all board outputs at 0.
REQ-025 SHALL drop any response in flight when reset asserts mid-request; the first request after release SHALL be serviced normally.

Configuration
REQ-026 SHALL honour macro MMIO_PWM_EN: if defined, an 8-bit free-running counter p drives RGB_x = (p < colour byte), so 0x00 is off and 0xFF is on for 255 of 256 cycles.
REQ-027 SHALL, without MMIO_PWM_EN, omit the PWM counter and drive RGB_x = bit 7 of the colour byte.

Structure
REQ-028 SHALL take address constants, the funct3 enum and the LEDREG byte-lane indices from shared package mmio_pkg.
REQ-029 SHALL instantiate one sub-module mmio_timebase (prescaler, MICROS, MILLIS, CLK_FREQ_HZ parameter).

Verification
REQ-030 SHALL cover four SB of 0xC0 to 0xFFFFFFFC..0xFFFFFFFF then LW 0xFFFFFFFC -> 0xC0C0C0C0; LH -> 0xFFFFC0C0; LHU -> 0x0000C0C0; LB -> 0xFFFFFFC0; LBU -> 0x000000C0.
REQ-031 SHALL cover CLK_FREQ_HZ = 12000000 with 12000 cycles after reset release, then LW 0xFFFFFFF4 -> 1000 and LW 0xFFFFFFF8 -> 1.
REQ-032 SHALL cover SW 0x12345678 to 0xFFFFFFF4, then LW 0xFFFFFFF4 -> unchanged counter value; LW 0x00000100 -> 0, resp_err = 0.
REQ-033 SHALL cover LW 0xFFFFFFFE -> resp_err = 1, rdata 0; SH 0xFFFFFFFD -> resp_err = 1, LEDREG unchanged.
REQ-034 SHALL cover, with MMIO_PWM_EN, SW 0x80000001: LED = 1 and RGB_R high for exactly 128 of 256 cycles; without the macro, RGB_R held at 1.
REQ-035 SHALL cover reset asserted the cycle after a req_valid: resp_valid stays 0 and LEDREG reads 0 afterwards.
